// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and frame-memory geometry for the
// vga_frame_reader slice.
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_IMG_W = 128;
  localparam int VGA_IMG_H = 96;
  localparam int VGA_SCALE = 5;
  localparam int ADDR_W    = 14;

  // Both raster counters share one width, sized for the longer axis.
  localparam int CNT_W = $clog2(H_TOTAL);

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  function automatic logic in_range(input logic [CNT_W-1:0] value,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick, raster counters and one-pixel-delayed sync generation for the
// VGA scan; also flags the visible area and line/frame ends for the top level.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en,
  output logic visible,
  output logic v_active,
  output logic last_col,
  output logic line_end,
  output logic frame_end,
  output logic hsync,
  output logic vsync
);

  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_VIS_LAST = CNT_W'(H_VISIBLE - 1);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  logic             pix_en_q, pix_en_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;

  assign pix_en    = pix_en_q;
  assign v_active  = (v_cnt_q < V_VIS);
  assign visible   = (h_cnt_q < H_VIS) && v_active;
  assign last_col  = (h_cnt_q == H_VIS_LAST);
  assign line_end  = (h_cnt_q == H_LAST);
  assign frame_end = line_end && (v_cnt_q == V_LAST);
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;

  // Sync is sampled from the counters on the tick, so it leaves one pixel
  // behind them, in step with the registered colour.
  always_comb begin
    pix_en_d = ~pix_en_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    if (pix_en_q) begin
      hsync_d = ~in_range(h_cnt_q, HS_START, HS_END);
      vsync_d = ~in_range(v_cnt_q, VS_START, VS_END);
      if (line_end) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pix_en_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
    end else begin
      pix_en_q <= pix_en_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Read-side scan controller: walks the frame memory in raster order with 5x5
// pixel replication and registers colour in step with sync.
// Define VGA_TEST_PATTERN_EN to replace memory data with a generated pattern.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int IMG_W     = VGA_IMG_W,
  parameter int IMG_H     = VGA_IMG_H,
  parameter int SCALE     = VGA_SCALE
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] address,
  input  logic              red_in,
  input  logic              green_in,
  input  logic              blue_in,
  output logic              hsync,
  output logic              vsync,
  output logic              red,
  output logic              green,
  output logic              blue
);

  localparam int                SUB_W      = $clog2(SCALE);
  localparam int                X_W        = $clog2(IMG_W);
  localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(SCALE - 1);
  localparam logic [X_W-1:0]    X_LAST     = X_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'((IMG_H - 1) * IMG_W);

  logic pix_en, visible, v_active, last_col, line_end, frame_end;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .visible   (visible),
    .v_active  (v_active),
    .last_col  (last_col),
    .line_end  (line_end),
    .frame_end (frame_end),
    .hsync     (hsync),
    .vsync     (vsync)
  );

  logic [SUB_W-1:0]  x_sub_q, x_sub_d;
  logic [X_W-1:0]    x_img_q, x_img_d;
  logic [SUB_W-1:0]  y_sub_q, y_sub_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  rgb_t              rgb_q, rgb_d;
  rgb_t              src_rgb;

`ifdef VGA_TEST_PATTERN_EN
  logic [ADDR_W-X_W-1:0] y_img;
  assign y_img   = row_base_q[ADDR_W-1:X_W];
  assign src_rgb = {x_img_q[3], y_img[3], x_img_q[4] ^ y_img[4]};
`else
  assign src_rgb = {red_in, green_in, blue_in};
`endif

  // Walk state always describes the pixel at the current counters; the
  // address is loaded on the off-tick clk so memory data lands on the next tick.
  always_comb begin
    x_sub_d    = x_sub_q;
    x_img_d    = x_img_q;
    y_sub_d    = y_sub_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    rgb_d      = rgb_q;
    if (pix_en) begin
      rgb_d = visible ? src_rgb : '0;
      if (visible && !last_col) begin
        if (x_sub_q == SUB_LAST) begin
          x_sub_d = '0;
          x_img_d = (x_img_q == X_LAST) ? x_img_q : x_img_q + 1'b1;
        end else begin
          x_sub_d = x_sub_q + 1'b1;
        end
      end
      if (line_end) begin
        x_sub_d = '0;
        x_img_d = '0;
        if (v_active) begin
          if (y_sub_q == SUB_LAST) begin
            y_sub_d = '0;
            if (row_base_q != ROW_LAST) begin
              row_base_d = row_base_q + ROW_STRIDE;
            end
          end else begin
            y_sub_d = y_sub_q + 1'b1;
          end
        end
      end
      // Frame restart overrides any row advance decided above.
      if (frame_end) begin
        y_sub_d    = '0;
        row_base_d = '0;
      end
    end else if (visible) begin
      addr_d = row_base_q + ADDR_W'(x_img_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_sub_q    <= '0;
      x_img_q    <= '0;
      y_sub_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      rgb_q      <= '0;
    end else begin
      x_sub_q    <= x_sub_d;
      x_img_q    <= x_img_d;
      y_sub_q    <= y_sub_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      rgb_q      <= rgb_d;
    end
  end

  assign address = addr_q;
  assign red     = rgb_q.r;
  assign green   = rgb_q.g;
  assign blue    = rgb_q.b;

endmodule
